// File: rtl/hfosc_sequencer.sv
// rtl/hfosc_sequencer.sv - HF oscillator power sequencer answering PMU clock requests
//
// Sequences the oscillator power-up/enable controls from the PMU clock request.
// The sequence has settle, start, drain and minimum-off intervals. Runs on the
// always-on slow clock.
//
// Ports:
//   clk          always-on slow clock, posedge
//   rst_n        asynchronous active-low reset
//   req_powerup  PMU clkhf_powerup request
//   req_enable   PMU clkhf_enable request
//   wake         external wake, forces an on-request while high
//   clr_stats    single-cycle pulse clearing on_count
//   osc_powerup  oscillator CLKHFPU
//   osc_enable   oscillator CLKHFEN
//   clk_ready    fast clock stable and usable
//   busy         sequencing in progress (POWERING, STARTING, STOPPING)
//   on_count     saturating count of cycles spent in ON
module hfosc_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned MIN_OFF_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_powerup,
    input  logic        req_enable,
    input  logic        wake,
    input  logic        clr_stats,
    output logic        osc_powerup,
    output logic        osc_enable,
    output logic        clk_ready,
    output logic        busy,
    output logic [31:0] on_count
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_OFF      = 3'd0;
    localparam logic [2:0] S_POWERING = 3'd1;
    localparam logic [2:0] S_STARTING = 3'd2;
    localparam logic [2:0] S_ON       = 3'd3;
    localparam logic [2:0] S_STOPPING = 3'd4;

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LD   = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD   = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_LD = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             osc_powerup_q, osc_powerup_d;
    logic             osc_enable_q, osc_enable_d;
    logic             clk_ready_q, clk_ready_d;
    logic             busy_q, busy_d;
    logic [31:0]      on_count_q, on_count_d;

    logic             req_on;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    assign req_on   = (req_powerup & req_enable) | wake;
    assign cnt_zero = (cnt_q == '0);
    // The shared counter holds at zero. In OFF, zero means min-off has elapsed,
    // so a request held off during min-off is still honoured afterwards.
    assign cnt_dec  = cnt_zero ? cnt_q : (cnt_q - CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_dec;
        case (state_q)
            S_OFF: begin
                if (req_on && cnt_zero) begin
                    state_d = S_POWERING;
                    cnt_d   = SETTLE_LD;
                end
            end
            S_POWERING: begin
                // Abort beats settle completion; enable has not risen yet, so no drain.
                if (!req_on) begin
                    state_d = S_OFF;
                    cnt_d   = MIN_OFF_LD;
                end else if (cnt_zero) begin
                    state_d = S_STARTING;
                    cnt_d   = START_LD;
                end
            end
            S_STARTING: begin
                if (!req_on) begin
                    state_d = S_STOPPING;
                    cnt_d   = DRAIN_LD;
                end else if (cnt_zero) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (!req_on) begin
                    state_d = S_STOPPING;
                    cnt_d   = DRAIN_LD;
                end
            end
            S_STOPPING: begin
                // The oscillator is still running, so a renewed request resumes at once.
                if (req_on) begin
                    state_d = S_ON;
                end else if (cnt_zero) begin
                    state_d = S_OFF;
                    cnt_d   = MIN_OFF_LD;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that they stay registered and
    // line up with the state register.
    always_comb begin
        osc_powerup_d = (state_d != S_OFF);
        osc_enable_d  = (state_d == S_STARTING) || (state_d == S_ON) || (state_d == S_STOPPING);
        clk_ready_d   = (state_d == S_ON);
        busy_d        = (state_d == S_POWERING) || (state_d == S_STARTING) ||
                        (state_d == S_STOPPING);
    end

    always_comb begin
        on_count_d = on_count_q;
        if (clr_stats) begin
            on_count_d = '0;
        end else if ((state_q == S_ON) && (on_count_q != 32'hFFFF_FFFF)) begin
            on_count_d = on_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_OFF;
            cnt_q         <= '0;
            osc_powerup_q <= 1'b0;
            osc_enable_q  <= 1'b0;
            clk_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            on_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            osc_powerup_q <= osc_powerup_d;
            osc_enable_q  <= osc_enable_d;
            clk_ready_q   <= clk_ready_d;
            busy_q        <= busy_d;
            on_count_q    <= on_count_d;
        end
    end

    assign osc_powerup = osc_powerup_q;
    assign osc_enable  = osc_enable_q;
    assign clk_ready   = clk_ready_q;
    assign busy        = busy_q;
    assign on_count    = on_count_q;

endmodule

// File: tb/tb_hfosc_sequencer.sv
// tb/tb_hfosc_sequencer.sv - self-checking bench for hfosc_sequencer
module tb_hfosc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_powerup = 1'b0;
    logic        req_enable = 1'b0;
    logic        wake = 1'b0;
    logic        clr_stats = 1'b0;
    logic        osc_powerup;
    logic        osc_enable;
    logic        clk_ready;
    logic        busy;
    logic [31:0] on_count;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rp, re, wk, clr;
        logic        pu, en, rdy, bsy;
        logic        chk;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        logic        pu, en, rdy, bsy;
        logic        chk;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    hfosc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_powerup (req_powerup),
        .req_enable  (req_enable),
        .wake        (wake),
        .clr_stats   (clr_stats),
        .osc_powerup (osc_powerup),
        .osc_enable  (osc_enable),
        .clk_ready   (clk_ready),
        .busy        (busy),
        .on_count    (on_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rp, re, wk, clr, pu, en, rdy, bsy,
                                input logic chk, input logic [31:0] cnt);
        vec_t v;
        v.rp = rp; v.re = re; v.wk = wk; v.clr = clr;
        v.pu = pu; v.en = en; v.rdy = rdy; v.bsy = bsy;
        v.chk = chk; v.cnt = cnt;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, and check it after the edge.
    task automatic step(input logic rp, re, wk, clr, pu, en, rdy, bsy,
                        input logic chk, input logic [31:0] cnt, input string name);
        exp_t e;
        req_powerup = rp;
        req_enable  = re;
        wake        = wk;
        clr_stats   = clr;
        e.pu = pu; e.en = en; e.rdy = rdy; e.bsy = bsy;
        e.chk = chk; e.cnt = cnt; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests_run++;
        if ({osc_powerup, osc_enable, clk_ready, busy} !== {e.pu, e.en, e.rdy, e.bsy} ||
            (e.chk && on_count !== e.cnt)) begin
            tests_failed++;
            $display("FAIL %s: pu/en/rdy/busy=%b%b%b%b on_count=%h, expected %b%b%b%b on_count=%h%s",
                     e.name, osc_powerup, osc_enable, clk_ready, busy, on_count,
                     e.pu, e.en, e.rdy, e.bsy, e.cnt, e.chk ? "" : " (count unchecked)");
        end
    endtask

    task automatic check_idle(input string name);
        tests_run++;
        if ({osc_powerup, osc_enable, clk_ready, busy} !== 4'b0000 || on_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL %s: pu/en/rdy/busy=%b%b%b%b on_count=%h, expected 0000 on_count=0",
                     name, osc_powerup, osc_enable, clk_ready, busy, on_count);
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        req_powerup = 1'b0; req_enable = 1'b0; wake = 1'b0; clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle(name);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full power-up from OFF with min-off already satisfied: 11 edges to clk_ready.
    task automatic run_to_on(input string tag);
        for (int k = 1; k <= 11; k++)
            step(1, 1, 0, 0, 1, (k >= 9), (k >= 11), (k <= 10), 0, 32'd0,
                 $sformatf("%s_up[%0d]", tag, k));
    endtask

    initial begin
        // Vector table: requests that do not form req_on, test 1 power-up,
        // test 2 shutdown and the re-request that waits out min-off.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'd0));
        for (int k = 1; k <= 12; k++)
            vecs.push_back(mk(1, 1, 0, 0, 1, (k >= 9), (k >= 11), (k <= 10), 1,
                              (k >= 12) ? 32'(k - 11) : 32'd0));
        for (int d = 1; d <= 5; d++)
            vecs.push_back(mk(0, 0, 0, 0, (d <= 4), (d <= 4), 0, (d <= 4), 1, 32'd2));
        for (int j = 1; j <= 26; j++)
            vecs.push_back(mk(1, 1, 0, 0, (j >= 16), (j >= 24), (j >= 26),
                              (j >= 16 && j <= 25), 1, 32'd2));

        do_reset("reset_state");
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rp, vecs[i].re, vecs[i].wk, vecs[i].clr,
                 vecs[i].pu, vecs[i].en, vecs[i].rdy, vecs[i].bsy,
                 vecs[i].chk, vecs[i].cnt, $sformatf("vec[%0d]", i));

        // Test 3: abort in POWERING cycle 3, enable never rises, min-off restarts.
        do_reset("t3_reset");
        for (int k = 1; k <= 3; k++)
            step(1, 1, 0, 0, 1, 0, 0, 1, 0, 32'd0, $sformatf("t3_pwr[%0d]", k));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, "t3_abort");
        for (int j = 1; j <= 16; j++)
            step(1, 1, 0, 0, (j >= 16), 0, 0, (j >= 16), 0, 32'd0,
                 $sformatf("t3_minoff[%0d]", j));

        // Abort on the very cycle settle completes: OFF, not STARTING.
        do_reset("prio_reset");
        for (int k = 1; k <= 8; k++)
            step(1, 1, 0, 0, 1, 0, 0, 1, 0, 32'd0, $sformatf("prio_pwr[%0d]", k));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, "prio_abort");

        // Test 4: wake in STOPPING cycle 2 returns to ON without dropping enable.
        do_reset("t4_reset");
        run_to_on("t4");
        step(0, 0, 0, 0, 1, 1, 0, 1, 0, 32'd0, "t4_stop1");
        step(0, 0, 0, 0, 1, 1, 0, 1, 0, 32'd0, "t4_stop2");
        step(0, 0, 1, 0, 1, 1, 1, 0, 0, 32'd0, "t4_wake_on");
        step(0, 0, 1, 0, 1, 1, 1, 0, 0, 32'd0, "t4_wake_hold");

        // Test 5: on_count saturation and clear priority, still ON via wake.
        force dut.on_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.on_count_q;
        step(0, 0, 1, 0, 1, 1, 1, 0, 1, 32'hFFFF_FFFF, "t5_reach_max");
        step(0, 0, 1, 0, 1, 1, 1, 0, 1, 32'hFFFF_FFFF, "t5_saturate");
        step(0, 0, 1, 1, 1, 1, 1, 0, 1, 32'd0, "t5_clear");
        step(0, 0, 1, 0, 1, 1, 1, 0, 1, 32'd1, "t5_restart");

        // Test 6: asynchronous reset in STARTING, then a full sequence.
        do_reset("t6_reset");
        for (int k = 1; k <= 9; k++)
            step(1, 1, 0, 0, 1, (k >= 9), 0, 1, 0, 32'd0, $sformatf("t6_pre[%0d]", k));
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("t6_async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_to_on("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
